// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// ps2_pkg : shared PS/2 definitions (FSM states, error codes, keyboard bytes)
// Revision: 1.0 - initial release
// ============================================================================
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_START     = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } ps2_state_e;

    localparam logic [1:0] ERR_NONE          = 2'b00;
    localparam logic [1:0] ERR_START_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_BIT_TIMEOUT   = 2'b10;
    localparam logic [1:0] ERR_NO_ACK        = 2'b11;

    localparam logic [7:0] CMD_SET_LED  = 8'hED;
    localparam logic [7:0] CMD_ECHO     = 8'hEE;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] ACK_BYTE     = 8'hFA;
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

    // Data bits, parity and stop; the start bit is driven separately during inhibit.
    localparam int FRAME_BITS = 10;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// ps2_line_filter : 2-FF synchronizer, stability filter and falling-edge pulse
// Revision: 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILT_LEN = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall_evt
);

    localparam int             c_CW   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(FILT_LEN - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_fall;
    logic [c_CW-1:0] r_cnt;

    // Idle PS/2 lines are pulled high, so reset to the released level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= pin;
            r_sync2 <= r_sync1;
            r_fall  <= 1'b0;
            if (r_sync2 != r_level) begin
                if (r_cnt == c_LAST) begin
                    r_level <= r_sync2;
                    r_fall  <= ~r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CW'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign level    = r_level;
    assign fall_evt = r_fall;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
// ps2_host_tx : PS/2 host-to-device command transmitter with ACK check
// Revision: 1.0 - initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int BIT_TIMEOUT    = 200000,
    parameter int FILT_LEN       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code
);

    localparam int c_T_MAX_SB = (START_TIMEOUT > BIT_TIMEOUT) ? START_TIMEOUT : BIT_TIMEOUT;
    localparam int c_T_MAX    = (c_T_MAX_SB > INHIBIT_CYCLES) ? c_T_MAX_SB : INHIBIT_CYCLES;
    localparam int c_TW       = $clog2(c_T_MAX + 1);

    localparam logic [c_TW-1:0] c_INH_LAST   = c_TW'(INHIBIT_CYCLES - 1);
    localparam logic [c_TW-1:0] c_INH_PRE    = c_TW'(INHIBIT_CYCLES - 2);
    localparam logic [c_TW-1:0] c_START_LAST = c_TW'(START_TIMEOUT - 1);
    localparam logic [c_TW-1:0] c_BIT_LAST   = c_TW'(BIT_TIMEOUT - 1);
    localparam logic [3:0]      c_STOP_EDGE  = 4'd9;

    ps2_state_e            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [3:0]            r_bitcnt;
    logic [c_TW-1:0]       r_cnt;
    logic                  r_clk_oe;
    logic                  r_data_oe;
    logic                  r_tx_ready;
    logic                  r_busy;
    logic                  r_tx_done;
    logic                  r_tx_err;
    logic [1:0]            r_err_code;

    logic            w_clk_level;
    logic            w_clk_fall;
    logic            w_data_level;
    logic            w_data_fall_unused;
    logic [c_TW-1:0] w_limit;
    logic [c_TW-1:0] w_cnt_next;
    logic            w_line_idle;
    logic            w_timed;
    logic            w_expired;
    logic            w_ack_bad;
    logic            w_fail;
    logic [1:0]      w_fail_code;

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
        .clk      (clk),
        .rst      (rst),
        .pin      (ps2_clk_in),
        .level    (w_clk_level),
        .fall_evt (w_clk_fall)
    );

    ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_data_filt (
        .clk      (clk),
        .rst      (rst),
        .pin      (ps2_data_in),
        .level    (w_data_level),
        .fall_evt (w_data_fall_unused)
    );

    // Per-edge watchdog: reloads on every device falling edge, saturates otherwise.
    always_comb begin
        w_limit     = c_BIT_LAST;
        if (r_state == ST_START) begin
            w_limit = c_START_LAST;
        end
        w_cnt_next  = r_cnt;
        if (w_clk_fall) begin
            w_cnt_next = '0;
        end else if (r_cnt != '1) begin
            w_cnt_next = r_cnt + c_TW'(1);
        end
        w_line_idle = w_clk_level & w_data_level;
        w_timed     = (r_state == ST_START) || (r_state == ST_SHIFT) || (r_state == ST_ACK) ||
                      ((r_state == ST_WAIT_IDLE) && !w_line_idle);
        w_expired   = w_timed && !w_clk_fall && (r_cnt >= w_limit);
        w_ack_bad   = (r_state == ST_ACK) && w_clk_fall && w_data_level;
        w_fail      = w_expired | w_ack_bad;
        w_fail_code = ERR_NONE;
        if (w_expired) begin
            w_fail_code = (r_state == ST_START) ? ERR_START_TIMEOUT : ERR_BIT_TIMEOUT;
        end else if (w_ack_bad) begin
            w_fail_code = ERR_NO_ACK;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bitcnt   <= '0;
            r_cnt      <= '0;
            r_clk_oe   <= 1'b0;
            r_data_oe  <= 1'b0;
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_tx_done  <= 1'b0;
            r_tx_err   <= 1'b0;
            r_err_code <= ERR_NONE;
            if (w_fail) begin
                r_state    <= ST_IDLE;
                r_clk_oe   <= 1'b0;
                r_data_oe  <= 1'b0;
                r_tx_err   <= 1'b1;
                r_err_code <= w_fail_code;
                r_busy     <= 1'b0;
                r_tx_ready <= 1'b1;
                r_cnt      <= '0;
                r_bitcnt   <= '0;
                r_shift    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (tx_valid && r_tx_ready) begin
                            r_shift    <= {1'b1, odd_parity(tx_data), tx_data};
                            r_cnt      <= '0;
                            r_bitcnt   <= '0;
                            r_clk_oe   <= 1'b1;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_INHIBIT;
                        end
                    end
                    ST_INHIBIT: begin
                        if (r_cnt == c_INH_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_cnt    <= '0;
                            r_state  <= ST_START;
                        end else begin
                            r_cnt <= r_cnt + c_TW'(1);
                            // Start bit appears in the final inhibit cycle.
                            if (r_cnt == c_INH_PRE) begin
                                r_data_oe <= 1'b1;
                            end
                        end
                    end
                    ST_START: begin
                        r_cnt <= w_cnt_next;
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                            r_bitcnt  <= 4'd1;
                            r_state   <= ST_SHIFT;
                        end
                    end
                    ST_SHIFT: begin
                        r_cnt <= w_cnt_next;
                        if (w_clk_fall) begin
                            r_data_oe <= ~r_shift[0];
                            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
                            r_bitcnt  <= r_bitcnt + 4'd1;
                            if (r_bitcnt == c_STOP_EDGE) begin
                                r_state <= ST_ACK;
                            end
                        end
                    end
                    ST_ACK: begin
                        r_cnt <= w_cnt_next;
                        if (w_clk_fall) begin
                            r_state <= ST_WAIT_IDLE;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (w_line_idle) begin
                            r_tx_done  <= 1'b1;
                            r_busy     <= 1'b0;
                            r_tx_ready <= 1'b1;
                            r_cnt      <= '0;
                            r_bitcnt   <= '0;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_cnt <= w_cnt_next;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign tx_done     = r_tx_done;
    assign tx_err      = r_tx_err;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
// tb_ps2_host_tx : self-checking bench with a behavioural PS/2 keyboard model
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int T_INH   = 100;
    localparam int T_START = 5000;
    localparam int T_BIT   = 2000;
    localparam int T_FILT  = 4;
    localparam int HALF    = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES (T_INH),
        .START_TIMEOUT  (T_START),
        .BIT_TIMEOUT    (T_BIT),
        .FILT_LEN       (T_FILT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe),
        .busy        (busy),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code)
    );

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Length of each clock-inhibit pulse and the cycle the clock was released.
    int     inh_run = 0, inh_len = 0, inh_count = 0;
    longint clk_rel_cyc = 0;
    always @(negedge clk) begin
        if (ps2_clk_oe) begin
            inh_run <= inh_run + 1;
        end else if (inh_run > 0) begin
            inh_len     <= inh_run;
            inh_count   <= inh_count + 1;
            clk_rel_cyc <= cyc;
            inh_run     <= 0;
        end
    end

    // Keyboard model: answers request-to-send, clocks dev_edges falls, samples on rises.
    int         dev_edges = 11;
    bit         dev_ack = 1'b1;
    bit         dev_busy = 1'b0;
    int         dev_edge_cnt = 0;
    logic [9:0] dev_bits = '0;
    longint     dev_last_fall = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (dev_edges > 0 && ps2_clk_in && !ps2_data_in && !dev_busy) begin
                dev_busy     = 1'b1;
                dev_edge_cnt = 0;
                dev_bits     = '0;
                repeat (20) @(negedge clk);
                for (int k = 1; k <= dev_edges; k++) begin
                    dev_clk       = 1'b0;
                    dev_edge_cnt  = k;
                    dev_last_fall = cyc;
                    repeat (HALF) @(negedge clk);
                    dev_clk = 1'b1;
                    if (k <= 10) dev_bits[k-1] = ps2_data_in;
                    if (k == 10 && dev_ack) dev_data = 1'b0;
                    repeat (HALF) @(negedge clk);
                end
                dev_data = 1'b1;
                for (int w = 0; w < 20000 && !ps2_data_in; w++) @(negedge clk);
                dev_busy = 1'b0;
            end
        end
    end

    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic par;
        par = (($countones(d) % 2) == 0);
        return {1'b1, par, d};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_tx(input logic [7:0] d, input int ne, input bit ack, input int extra_at,
                         output bit got_done, output bit got_err, output logic [1:0] code,
                         output longint evt_cyc);
        int n;
        bit seen;
        got_done = 0; got_err = 0; code = 2'b00; evt_cyc = 0;
        dev_edges = ne; dev_ack = ack;
        n = 0;
        while (!tx_ready && n < 5000) begin @(negedge clk); n++; end
        check("ready_before_request", {31'd0, tx_ready}, 1);
        @(negedge clk); tx_data = d; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0; tx_data = 8'($urandom);
        check("accept_ready_busy", {30'd0, tx_ready, busy}, 2'b01);
        seen = 0;
        for (int i = 0; i < 20000 && !seen; i++) begin
            @(negedge clk);
            if (i == extra_at) begin tx_valid = 1'b1; tx_data = 8'($urandom); end
            else tx_valid = 1'b0;
            if (tx_done || tx_err) begin
                seen = 1; got_done = tx_done; got_err = tx_err; code = err_code; evt_cyc = cyc;
                check("lines_released_at_end", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
                check("done_err_exclusive", {31'd0, tx_done & tx_err}, 0);
            end
        end
        tx_valid = 1'b0;
        check("result_within_budget", {31'd0, seen}, 1);
        @(negedge clk);
        check("result_single_pulse", {30'd0, tx_done, tx_err}, 0);
        check("idle_after_result", {30'd0, tx_ready, busy}, 2'b10);
        n = 0;
        while (dev_busy && n < 20000) begin @(negedge clk); n++; end
        check("device_idle", {31'd0, dev_busy}, 0);
    endtask

    typedef struct {
        logic [7:0] d;
        int         ne;
        bit         ack;
        bit         exp_done;
        logic [1:0] exp_code;
        bit         exp_par;
    } vec_t;

    vec_t       tbl [7];
    bit         gd, ge;
    logic [1:0] code;
    longint     ev, dt;
    int         n, inh0;
    logic [7:0] rd;
    bit         rack;

    initial begin
        tbl[0] = '{8'hED, 11, 1'b1, 1'b1, ERR_NONE,          1'b1};
        tbl[1] = '{8'h00, 11, 1'b1, 1'b1, ERR_NONE,          1'b1};
        tbl[2] = '{8'hFF, 11, 1'b1, 1'b1, ERR_NONE,          1'b1};
        tbl[3] = '{8'h01, 11, 1'b1, 1'b1, ERR_NONE,          1'b0};
        tbl[4] = '{8'hA5,  0, 1'b1, 1'b0, ERR_START_TIMEOUT, 1'b0};
        tbl[5] = '{8'h3C,  5, 1'b1, 1'b0, ERR_BIT_TIMEOUT,   1'b0};
        tbl[6] = '{8'h5A, 11, 1'b0, 1'b0, ERR_NO_ACK,        1'b1};

        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready_busy", {30'd0, tx_ready, busy}, 2'b10);
        check("reset_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("reset_done_err_code", {28'd0, tx_done, tx_err, err_code}, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        for (int t = 0; t < 7; t++) begin
            do_tx(tbl[t].d, tbl[t].ne, tbl[t].ack, -1, gd, ge, code, ev);
            check($sformatf("vec%0d_done", t), {31'd0, gd}, {31'd0, tbl[t].exp_done});
            check($sformatf("vec%0d_err", t), {31'd0, ge}, {31'd0, !tbl[t].exp_done});
            check($sformatf("vec%0d_code", t), {30'd0, code}, {30'd0, tbl[t].exp_code});
            check($sformatf("vec%0d_inhibit_len", t), 32'(inh_len), T_INH);
            if (tbl[t].ne >= 10) begin
                check($sformatf("vec%0d_data_bits", t), {24'd0, dev_bits[7:0]}, {24'd0, tbl[t].d});
                check($sformatf("vec%0d_parity", t), {31'd0, dev_bits[8]}, {31'd0, tbl[t].exp_par});
                check($sformatf("vec%0d_stop", t), {31'd0, dev_bits[9]}, 1);
            end
            if (tbl[t].exp_code == ERR_START_TIMEOUT) begin
                check("start_timeout_latency", 32'(ev - clk_rel_cyc), T_START);
            end
            if (tbl[t].exp_code == ERR_BIT_TIMEOUT) begin
                dt = ev - dev_last_fall;
                check("bit_timeout_window", {31'd0, (dt >= T_BIT) && (dt <= T_BIT + T_FILT + 4)}, 1);
            end
        end

        for (int r = 0; r < 12; r++) begin
            rd   = 8'($urandom);
            rack = ($urandom_range(0, 3) != 0);
            do_tx(rd, 11, rack, -1, gd, ge, code, ev);
            check("rnd_done", {31'd0, gd}, {31'd0, rack});
            check("rnd_code", {30'd0, code}, rack ? 32'(ERR_NONE) : 32'(ERR_NO_ACK));
            check("rnd_frame", {22'd0, dev_bits}, {22'd0, model_frame(rd)});
        end

        // Asynchronous abort in the middle of the data bits.
        dev_edges = 11; dev_ack = 1'b1; dev_edge_cnt = 0;
        @(negedge clk); tx_data = CMD_ECHO; tx_valid = 1'b1;
        @(negedge clk); tx_valid = 1'b0;
        n = 0;
        while (dev_edge_cnt < 4 && n < 5000) begin @(negedge clk); n++; end
        check("abort_reached_shift", {31'd0, dev_edge_cnt >= 4}, 1);
        #2 rst = 1'b0;
        #1;
        check("abort_oe_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
        check("abort_ready_busy", {30'd0, tx_ready, busy}, 2'b10);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        n = 0;
        while (dev_busy && n < 20000) begin @(negedge clk); n++; end
        check("abort_device_idle", {31'd0, dev_busy}, 0);

        inh0 = inh_count;
        do_tx(CMD_RESET, 11, 1'b1, 30, gd, ge, code, ev);
        check("post_reset_done", {31'd0, gd}, 1);
        check("post_reset_frame", {22'd0, dev_bits}, {22'd0, model_frame(CMD_RESET)});
        check("busy_request_ignored", 32'(inh_count - inh0), 1);
        repeat (300) @(negedge clk);
        check("no_extra_frame", 32'(inh_count - inh0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
